// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two requesters; 1-cycle or MULDIV_CYCLES execution.
// Optional macro ALU_DIVZERO_TRAP_EN: divide by zero skips the ALU and returns an all-ones/error response.
module alu_share_ctrl #(
  parameter int WIDTH         = 17,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  input  logic [WIDTH-1:0] alu_upper,
  input  logic [WIDTH-1:0] alu_lower,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_upper,
  output logic [WIDTH-1:0] rsp_lower,
  output logic             rsp_err,
  output logic             busy
);

`ifdef ALU_DIVZERO_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             pref1_q;
  logic [3:0]       cnt_q;
  logic             err_q;
  logic             trap_q;
  logic [3:0]       alu_op_q;
  logic [WIDTH-1:0] alu_data1_q, alu_data2_q;
  logic             rsp_valid_q, rsp_id_q, rsp_err_q, busy_q;
  logic [WIDTH-1:0] rsp_upper_q, rsp_lower_q;

  logic             gnt_vld, gnt_id, accept;
  logic [3:0]       acc_op;
  logic [WIDTH-1:0] acc_a, acc_b;
  logic             acc_supported, acc_muldiv, acc_dz;
  logic [3:0]       cnt_load;

  // pref1_q remembers who lost the last tie: set after granting req0.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) gnt_id = pref1_q;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && gnt_vld && !gnt_id && !rst;
  assign req1_ready = (state_q == IDLE) && gnt_vld &&  gnt_id && !rst;
  assign accept     = (state_q == IDLE) && gnt_vld;

  always_comb begin
    acc_op = gnt_id ? req1_op : req0_op;
    acc_a  = gnt_id ? req1_a  : req0_a;
    acc_b  = gnt_id ? req1_b  : req0_b;
    acc_supported = 1'b0;
    case (acc_op)
      4'b0000, 4'b0001, 4'b0100, 4'b0101,
      4'b0111, 4'b1000, 4'b1001, 4'b1011: acc_supported = 1'b1;
      default:                            acc_supported = 1'b0;
    endcase
    acc_muldiv = (acc_op == 4'b0100) || (acc_op == 4'b0101);
    acc_dz     = TRAP_EN && (acc_op == 4'b0101) && (acc_b == '0);
    cnt_load   = (acc_muldiv && !acc_dz) ? 4'(MULDIV_CYCLES) : 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pref1_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      trap_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_data1_q <= '0;
      alu_data2_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_upper_q <= '0;
      rsp_lower_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            alu_op_q    <= acc_op;
            alu_data1_q <= acc_a;
            alu_data2_q <= acc_b;
            rsp_id_q    <= gnt_id;
            pref1_q     <= ~gnt_id;
            cnt_q       <= cnt_load;
            err_q       <= ~acc_supported;
            trap_q      <= acc_dz;
            busy_q      <= 1'b1;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd1) begin
            rsp_upper_q <= trap_q ? '1 : alu_upper;
            rsp_lower_q <= trap_q ? '0 : alu_lower;
            rsp_err_q   <= err_q | trap_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_data1 = alu_data1_q;
  assign alu_data2 = alu_data2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_upper = rsp_upper_q;
  assign rsp_lower = rsp_lower_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed and random ops against a transaction-level reference model.
module tb_alu_share_ctrl;
  localparam int W   = 17;
  localparam int MDC = 4;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0100, OP_DIV = 4'b0101;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_data1, alu_data2, alu_upper, alu_lower;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_upper, rsp_lower;

  int checks = 0;
  int errors = 0;
  int last_gnt = -1;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W), .MULDIV_CYCLES(MDC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_upper(alu_upper), .alu_lower(alu_lower),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_upper(rsp_upper), .rsp_lower(rsp_lower), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in ALU: returns {upper, lower}.
  function automatic logic [2*W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0] up, lo;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'b0000: begin up = a + b; lo = '0; end
      4'b0001: begin up = a - b; lo = '0; end
      4'b0100: begin up = p[W-1:0]; lo = p[2*W-1:W]; end
      4'b0101: begin
        if (b == '0) begin up = '0; lo = a; end
        else begin up = a / b; lo = a % b; end
      end
      default: begin up = a ^ b; lo = a & b; end
    endcase
    return {up, lo};
  endfunction

  assign {alu_upper, alu_lower} = alu_fn(alu_op, alu_data1, alu_data2);

  function automatic void expect_rsp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] up, output logic [W-1:0] lo,
                                     output logic err, output int lat);
    {up, lo} = alu_fn(op, a, b);
    err = !(op inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1011});
    lat = (op == OP_MUL || op == OP_DIV) ? MDC : 1;
`ifdef ALU_DIVZERO_TRAP_EN
    if (op == OP_DIV && b == '0) begin up = '1; lo = '0; err = 1'b1; lat = 1; end
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out"}, 64'({alu_op, alu_data1, alu_data2, rsp_upper, rsp_lower}), 64'd0);
    chk({tag, "_flags"}, 64'({rsp_valid, rsp_id, rsp_err, busy}), 64'd0);
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eu, el, su, sl;
    logic ee;
    int elat, lat;
    expect_rsp(op, a, b, eu, el, ee, elat);
    if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    #1;
    chk("ready_sel", 64'({req1_ready, req0_ready}), (id == 0) ? 64'd1 : 64'd2);
    step();
    last_gnt = id;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req1_a = W'($urandom); req0_op = 4'($urandom); req1_op = 4'($urandom);
    chk("busy_acc", 64'(busy), 64'd1);
    chk("alu_in", 64'({alu_op, alu_data1, alu_data2}), 64'({op, a, b}));
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
      chk("alu_stable", 64'({alu_op, alu_data1, alu_data2}), 64'({op, a, b}));
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("rsp_id", 64'(rsp_id), 64'(id));
    chk("rsp_upper", 64'(rsp_upper), 64'(eu));
    chk("rsp_lower", 64'(rsp_lower), 64'(el));
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    chk("busy_resp", 64'(busy), 64'd1);
    su = rsp_upper; sl = rsp_lower;
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("hold_ready", 64'({req1_ready, req0_ready}), 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("hold_rsp", 64'({rsp_valid, busy, rsp_upper, rsp_lower}), 64'({2'b11, su, sl}));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs", 64'({rsp_valid, busy}), 64'd0);
  endtask

  logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hB, 4'h2, 4'hF};

  initial begin
    int t, g, elat, seen;
    logic [3:0] gop;
    logic [W-1:0] ga, gb, eu, el;
    logic ee;

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    step(); step();
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    chk_zero_outputs("rst");
    req0_valid = 1'b0;
    rst = 1'b0;
    step();

    issue(0, OP_ADD, 17'd5, 17'd3, 0);
    issue(1, OP_MUL, 17'd6, 17'd7, 0);
    issue(0, OP_SUB, 17'd20, 17'd5, 5);
    issue(1, 4'hF, 17'd1, 17'd2, 0);
    issue(0, OP_DIV, 17'd9, 17'd0, 0);
    issue(1, OP_DIV, 17'd100, 17'd7, 2);

    // Fairness from a fresh reset: both requesters always valid.
    rst = 1'b1; step(); rst = 1'b0; last_gnt = -1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = W'($urandom); req0_b = W'($urandom);
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = W'($urandom); req1_b = W'($urandom);
    #1;
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!(req0_ready || req1_ready) && t < 20) begin step(); t++; end
      chk("rr_both_ready", 64'(req0_ready & req1_ready), 64'd0);
      chk("rr_order", 64'({req1_ready, req0_ready}), (last_gnt == 0) ? 64'd2 : 64'd1);
      g = req1_ready ? 1 : 0;
      gop = g ? req1_op : req0_op; ga = g ? req1_a : req0_a; gb = g ? req1_b : req0_b;
      step();
      last_gnt = g;
      if (g == 1) begin req1_a = W'($urandom); req1_b = W'($urandom); end
      else        begin req0_a = W'($urandom); req0_b = W'($urandom); end
      expect_rsp(gop, ga, gb, eu, el, ee, elat);
      t = 0;
      while (!rsp_valid && t < 20) begin
        chk("rr_exec_ready", 64'({req1_ready, req0_ready}), 64'd0);
        step(); t++;
      end
      chk("rr_rsp", 64'({rsp_valid, rsp_id, rsp_upper}), 64'({1'b1, 1'(g), eu}));
      chk("rr_resp_ready", 64'({req1_ready, req0_ready}), 64'd0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step();

    for (int i = 0; i < 24; i++) begin
      issue(int'($urandom_range(0, 1)), ops[$urandom_range(0, 9)], W'($urandom),
            ($urandom_range(0, 3) == 0) ? '0 : W'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during the second EXEC cycle of a divide.
    req0_valid = 1'b1; req0_op = OP_DIV; req0_a = 17'd9; req0_b = 17'd7;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_zero_outputs("abort");
    req0_valid = 1'b1; #1;
    chk("abort_ready", 64'({req1_ready, req0_ready}), 64'd0);
    req0_valid = 1'b0;
    rst = 1'b0; last_gnt = -1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (rsp_valid) seen++; end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    rsp_ready = 1'b0;
    issue(1, OP_ADD, 17'h1FFFF, 17'd2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares the single combinational ALU between two requesters (req0, req1).
- Accepts one operation at a time through a valid/ready handshake and registers the operands and opcode that drive the ALU.
- Holds them stable for a single-cycle or multi-cycle execution window, captures the ALU result, and returns it with a valid/ready response handshake.
- Sits between the instruction/issue logic and the ALU.

Parameters:
- WIDTH, 17, data width of operands and results; matches the ALU Data/Upper/Lower width.
- MULDIV_CYCLES, 4, execution cycles allowed for multiply (4'b0100) and divide (4'b0101); legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  controller accepts req0 this cycle
- req0_op  input  4  requester 0 ALUOp
- req0_a  input  WIDTH  requester 0 operand 1
- req0_b  input  WIDTH  requester 0 operand 2
- req1_valid / req1_ready / req1_op / req1_a / req1_b  as for requester 0
- alu_op  output  4  registered ALUOp to ALU
- alu_data1  output  WIDTH  registered Data1 to ALU
- alu_data2  output  WIDTH  registered Data2 to ALU
- alu_upper  input  WIDTH  ALU Upper result
- alu_lower  input  WIDTH  ALU Lower result
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester that issued the op
- rsp_upper  output  WIDTH  captured Upper
- rsp_lower  output  WIDTH  captured Lower
- rsp_err  output  1  unsupported opcode (or div-by-zero, see option)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, rr pointer prefers req0, and every registered output is 0 (alu_op, alu_data1, alu_data2, rsp_valid, rsp_id, rsp_upper, rsp_lower, rsp_err, busy). reqN_ready=0 while rst is high. Reset mid-operation aborts: no response is produced and the in-flight op is dropped.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one valid, grant it. If both valid, grant the one not granted last; after reset, req0 wins.
  - reqN_ready = (state==IDLE) && grant==N && !rst. At most one ready is high at a time.
  - Accept on valid&&ready: latch op/a/b into alu_op/alu_data1/alu_data2, set rsp_id=N, update the rr pointer, go to EXEC.
  - Load cnt = MULDIV_CYCLES for op 0100/0101, otherwise 1.
- Supported opcodes: 0000 add, 0001 sub, 0100 mul, 0101 div, 0111, 1000, 1001, 1011. Any other op sets a pending error and uses cnt=1.
- EXEC: cnt decrements each cycle. When cnt==1, at the next edge capture rsp_upper=alu_upper, rsp_lower=alu_lower, rsp_err=pending error, set rsp_valid=1, and go to RESP.
- Latency from the accept edge to rsp_valid high: 1 cycle for single-cycle ops, MULDIV_CYCLES cycles for mul/div.
- alu_op/alu_data1/alu_data2 hold stable from accept until the next accept.
- RESP: rsp_valid and all rsp_* fields stay stable until rsp_ready is sampled high.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new request is accepted in the same cycle; the next accept is possible one cycle after the handshake.
- Result capture passes alu_upper/alu_lower through unchanged. Width truncation (e.g. of the product) is the ALU's concern.
- A requester dropping valid before it is accepted is legal and causes no grant.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: ALU_DIVZERO_TRAP_EN.
- Defined: op 0101 with operand b==0 is accepted but skips the MULDIV window (cnt=1). The response is rsp_upper = all ones, rsp_lower = 0, rsp_err = 1, and the ALU outputs are ignored.
- Undefined: divide-by-zero is handled like any divide, with the ALU value passed through and rsp_err=0.

Test Plan:
- Reset, then req0 add a=5 b=3, rsp_ready=1 -> req0_ready high in cycle 0; rsp_valid 1 cycle after accept with rsp_upper=8, rsp_id=0, rsp_err=0; busy high for 2 cycles.
- req1 mul a=6 b=7 with MULDIV_CYCLES=4 -> rsp_valid exactly 4 cycles after accept, rsp_upper=42, rsp_id=1; ALU inputs stable throughout.
- Both valid continuously with sub ops, rsp_ready=1 -> grant order 0,1,0,1; never both readys high.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp fields constant, no req_ready asserted, busy=1; accept resumes 1 cycle after the handshake.
- Op 4'b1111 -> rsp_err=1 after 1 cycle. Div a=9 b=0 -> with ALU_DIVZERO_TRAP_EN: rsp_upper=17'h1FFFF, rsp_err=1 after 1 cycle; without it: response after 4 cycles, rsp_err=0.
- rst asserted in EXEC cycle 2 of a div -> next cycle state IDLE, rsp_valid=0, outputs zero, and no response ever appears for that op.
